// File: rtl/response_signature_capture_if.sv
// Bus bundle between a stimulus/response source and the signature capture block.
// The source (master) drives the pattern stream and the golden table; the capture
// block (slave) reports run status, the captured truth table and the MISR signature.
interface response_signature_capture_if #(
  parameter int N_IN  = 4,
  parameter int SIG_W = 16
);
  localparam int N_PAT = 1 << N_IN;

  logic              start;
  logic              pat_valid;
  logic [N_IN-1:0]   pat;
  logic              resp;
  logic [N_PAT-1:0]  golden;

  logic              busy;
  logic              done;
  logic [N_PAT-1:0]  truth_tbl;
  logic [N_PAT-1:0]  covered;
  logic [SIG_W-1:0]  signature;
  logic              mismatch;
  logic [N_IN:0]     mismatch_cnt;
  logic [N_IN-1:0]   first_fail;
  logic              first_fail_v;

  modport master (
    output start, pat_valid, pat, resp, golden,
    input  busy, done, truth_tbl, covered, signature,
           mismatch, mismatch_cnt, first_fail, first_fail_v
  );

  modport slave (
    input  start, pat_valid, pat, resp, golden,
    output busy, done, truth_tbl, covered, signature,
           mismatch, mismatch_cnt, first_fail, first_fail_v
  );
endinterface

// File: rtl/response_signature_capture.sv
// Response signature capture for exhaustive-stimulus trojan screening.
// Records the single-bit DUT response per pattern into a truth table, compacts the
// response stream into a MISR, and counts responses that disagree with a golden
// table. Once every pattern has been seen the run finishes and a registered
// mismatch flag summarises the whole table.
module response_signature_capture #(
  parameter int               N_IN     = 4,
  parameter int               SIG_W    = 16,
  parameter logic [SIG_W-1:0] SIG_POLY = 16'h1021
) (
  input  logic                           CK,
  input  logic                           reset,
  response_signature_capture_if.slave    bus
);

  localparam int N_PAT = 1 << N_IN;
  localparam logic [N_IN:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [N_PAT-1:0]  truth_reg, truth_next;
  logic [N_PAT-1:0]  covered_reg, covered_next;
  logic [SIG_W-1:0]  sig_reg, sig_next;
  logic              mismatch_reg, mismatch_next;
  logic [N_IN:0]     cnt_reg, cnt_next;
  logic [N_IN-1:0]   ff_reg, ff_next;
  logic              ffv_reg, ffv_next;

  logic              capture_en;
  logic              resp_bad;
  logic              all_covered;
  logic [N_PAT-1:0]  hit;
  logic [SIG_W-1:0]  misr_step;

  // A start pulse pre-empts any capture in the same cycle, so the first pattern
  // of a fresh run is always taken on the cycle after start.
  assign capture_en  = (state_reg == S_CAPTURE) && bus.pat_valid && !bus.start;
  assign resp_bad    = (bus.resp != bus.golden[bus.pat]);
  assign all_covered = &covered_reg;

  // Galois-style MISR: shift left, fold the polynomial in on carry-out, inject resp at bit 0.
  assign misr_step = {sig_reg[SIG_W-2:0], 1'b0}
                   ^ (sig_reg[SIG_W-1] ? SIG_POLY : '0)
                   ^ {{(SIG_W-1){1'b0}}, bus.resp};

  // Per-pattern truth table and coverage bits; a duplicate pattern simply overwrites.
  for (genvar gi = 0; gi < N_PAT; gi++) begin : g_tbl
    assign hit[gi]          = capture_en && (bus.pat == N_IN'(gi));
    assign truth_next[gi]   = bus.start ? 1'b0 : (hit[gi] ? bus.resp : truth_reg[gi]);
    assign covered_next[gi] = bus.start ? 1'b0 : (hit[gi] | covered_reg[gi]);
  end

  // Next-state logic: start always (re)enters CAPTURE; the run ends on the edge after full coverage.
  always_comb begin
    state_next = state_reg;
    if (bus.start) begin
      state_next = S_CAPTURE;
    end else begin
      case (state_reg)
        S_IDLE:    state_next = S_IDLE;
        S_CAPTURE: if (all_covered) state_next = S_DONE;
        S_DONE:    state_next = S_DONE;
        default:   state_next = S_IDLE;
      endcase
    end
  end

  // Next-value logic for signature, fail counter, first-fail record and final verdict.
  always_comb begin
    sig_next      = sig_reg;
    cnt_next      = cnt_reg;
    ff_next       = ff_reg;
    ffv_next      = ffv_reg;
    mismatch_next = mismatch_reg;
    if (bus.start) begin
      sig_next      = '0;
      cnt_next      = '0;
      ff_next       = '0;
      ffv_next      = 1'b0;
      mismatch_next = 1'b0;
    end else begin
      if (capture_en) begin
        sig_next = misr_step;
        if (resp_bad) begin
          if (cnt_reg != CNT_MAX) cnt_next = cnt_reg + (N_IN+1)'(1);
          if (!ffv_reg) begin
            ff_next  = bus.pat;
            ffv_next = 1'b1;
          end
        end
      end
      // Verdict uses the table as it stands after this edge, so a late duplicate
      // capture in the finishing cycle is reflected in the flag.
      if ((state_reg == S_CAPTURE) && all_covered) begin
        mismatch_next = |(truth_next ^ bus.golden);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge CK) begin
    if (!reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Datapath registers; reset discards any partial run.
  always_ff @(posedge CK) begin
    if (!reset) begin
      truth_reg    <= '0;
      covered_reg  <= '0;
      sig_reg      <= '0;
      mismatch_reg <= 1'b0;
      cnt_reg      <= '0;
      ff_reg       <= '0;
      ffv_reg      <= 1'b0;
    end else begin
      truth_reg    <= truth_next;
      covered_reg  <= covered_next;
      sig_reg      <= sig_next;
      mismatch_reg <= mismatch_next;
      cnt_reg      <= cnt_next;
      ff_reg       <= ff_next;
      ffv_reg      <= ffv_next;
    end
  end

  assign bus.busy         = (state_reg == S_CAPTURE);
  assign bus.done         = (state_reg == S_DONE);
  assign bus.truth_tbl    = truth_reg;
  assign bus.covered      = covered_reg;
  assign bus.signature    = sig_reg;
  assign bus.mismatch     = mismatch_reg;
  assign bus.mismatch_cnt = cnt_reg;
  assign bus.first_fail   = ff_reg;
  assign bus.first_fail_v = ffv_reg;

endmodule
